// File: rtl/bcd_counter_pkg.sv
// Shared constants and helpers for the BCD modulus counter: digit width,
// active-low seven-segment patterns (g..a) and BCD digit utilities.
package bcd_counter_pkg;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic digit_valid(input logic [BCD_W-1:0] digit);
    return digit <= 4'd9;
  endfunction

  // Elaboration-time only: turns an integer parameter into a BCD constant.
  function automatic logic [4*BCD_W-1:0] to_bcd(input int value);
    logic [4*BCD_W-1:0] r;
    int v;
    r = '0;
    v = value;
    for (int d = 0; d < 4; d++) begin
      r[BCD_W*d +: BCD_W] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_seg_decoder.sv
// One BCD digit to an active-low seven-segment pattern (g..a); non-BCD
// codes show blank.
module bcd_seg_decoder
  import bcd_counter_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [6:0]       seg
);

  always_comb begin
    unique case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_mod_counter.sv
// Up/down BCD counter modulo MODULUS with validated synchronous load,
// cascade terminal count and per-digit seven-segment outputs.
module bcd_mod_counter
  import bcd_counter_pkg::*;
#(
  parameter int NDIGITS  = 2,
  parameter int MODULUS  = 60,
  parameter int BLANK_LZ = 0
) (
  input  logic                     KEY,
  input  logic                     SW,
  input  logic                     en,
  input  logic                     up,
  input  logic                     load,
  input  logic [BCD_W*NDIGITS-1:0] load_val,
  output logic [BCD_W*NDIGITS-1:0] count_bcd,
  output logic                     tc,
  output logic                     load_err,
  output logic [7*NDIGITS-1:0]     hex
);

  localparam int W = BCD_W * NDIGITS;
  localparam logic [4*BCD_W-1:0] MAX_FULL = to_bcd(MODULUS - 1);
  localparam logic [W-1:0]       MAX_BCD  = MAX_FULL[W-1:0];

  logic [W-1:0]       inc_val;
  logic [W-1:0]       dec_val;
  logic [W-1:0]       next_count;
  logic [NDIGITS-1:0] carry;
  logic [NDIGITS-1:0] borrow;
  logic [NDIGITS-1:0] digit_ok;
  logic               at_max;
  logic               at_zero;
  logic               load_ok;

  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
    logic [BCD_W-1:0] d;
    logic [6:0]       seg;
    logic             blank;

    assign d = count_bcd[BCD_W*i +: BCD_W];

    assign inc_val[BCD_W*i +: BCD_W] =
      !carry[i]   ? d : (d == 4'd9) ? 4'd0 : d + 4'd1;
    assign dec_val[BCD_W*i +: BCD_W] =
      !borrow[i]  ? d : (d == 4'd0) ? 4'd9 : d - 4'd1;

    if (i < NDIGITS - 1) begin : g_chain
      assign carry[i+1]  = carry[i]  & (d == 4'd9);
      assign borrow[i+1] = borrow[i] & (d == 4'd0);
    end

    assign digit_ok[i] = digit_valid(load_val[BCD_W*i +: BCD_W]);

    // A digit is a leading zero when it and every digit above it are zero.
    if (i > 0) begin : g_blank
      assign blank = (BLANK_LZ != 0) && (count_bcd[W-1:BCD_W*i] == '0);
    end else begin : g_noblank
      assign blank = 1'b0;
    end

    bcd_seg_decoder u_dec (
      .digit (d),
      .seg   (seg)
    );

    assign hex[7*i +: 7] = blank ? SEG_BLANK : seg;
  end

  assign at_max  = (count_bcd == MAX_BCD);
  assign at_zero = (count_bcd == '0);
  // Digits are valid here, so BCD ordering matches numeric ordering.
  assign load_ok = (&digit_ok) && (load_val <= MAX_BCD);

  assign tc = en & ~load & (up ? at_max : at_zero);

  always_comb begin
    // NOTE: default assignment first so every path drives next_count; no latch.
    next_count = count_bcd;
    if (load) begin
      if (load_ok) next_count = load_val;
    end else if (en) begin
      if (up) next_count = at_max  ? '0      : inc_val;
      else    next_count = at_zero ? MAX_BCD : dec_val;
    end
  end

  // NOTE: non-blocking assignments keep registered state race-free between blocks.
  always_ff @(posedge KEY or posedge SW) begin
    if (SW) begin
      count_bcd <= '0;
      load_err  <= 1'b0;
    end else begin
      count_bcd <= next_count;
      load_err  <= load & ~load_ok;
    end
  end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench: a default 2-digit mod-60 counter and a 3-digit mod-1000
// counter with leading-zero blanking, sharing clock and reset.
module tb_bcd_mod_counter;

  logic        KEY;
  logic        SW;
  logic        en, up, load;
  logic [7:0]  load_val;
  logic [7:0]  count_bcd;
  logic        tc, load_err;
  logic [13:0] hex;

  logic        en3, up3, load3;
  logic [11:0] load_val3;
  logic [11:0] count3;
  logic        tc3, load_err3;
  logic [20:0] hex3;

  int vectors     = 0;
  int miscompares = 0;

  bcd_mod_counter dut (
    .KEY       (KEY),
    .SW        (SW),
    .en        (en),
    .up        (up),
    .load      (load),
    .load_val  (load_val),
    .count_bcd (count_bcd),
    .tc        (tc),
    .load_err  (load_err),
    .hex       (hex)
  );

  bcd_mod_counter #(.NDIGITS(3), .MODULUS(1000), .BLANK_LZ(1)) dut3 (
    .KEY       (KEY),
    .SW        (SW),
    .en        (en3),
    .up        (up3),
    .load      (load3),
    .load_val  (load_val3),
    .count_bcd (count3),
    .tc        (tc3),
    .load_err  (load_err3),
    .hex       (hex3)
  );

  initial KEY = 1'b0;
  always #5 KEY = ~KEY;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge KEY);
    #1;
  endtask

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  initial begin
    SW = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;
    en3 = 1'b0; up3 = 1'b1; load3 = 1'b0; load_val3 = 12'h000;

    // Reset state
    #3;
    check("rst_count", 32'(count_bcd), 32'h00);
    check("rst_err", 32'(load_err), 32'h0);
    check("rst_hex", 32'(hex), 32'(14'b1000000_1000000));
    check("rst_hex3", 32'(hex3), 32'(21'b1111111_1111111_1000000));
    en = 1'b1; load = 1'b1; load_val = 8'h12;
    tick();
    check("rst_hold_count", 32'(count_bcd), 32'h00);
    load = 1'b0;
    #4 SW = 1'b0;

    // Up-count through one full cycle: 00..59, 00, 01
    #1;
    for (int k = 0; k <= 60; k++) begin
      check($sformatf("up_count_%0d", k), 32'(count_bcd), 32'(bcd2(k % 60)));
      check($sformatf("up_tc_%0d", k), 32'(tc), 32'((k % 60) == 59));
      tick();
    end
    check("up_after_wrap", 32'(count_bcd), 32'h01);

    // Down-count from 00
    load = 1'b1; load_val = 8'h00;
    tick();
    load = 1'b0; up = 1'b0;
    #1;
    check("dn_start", 32'(count_bcd), 32'h00);
    check("dn_tc_at_00", 32'(tc), 32'h1);
    tick();
    check("dn_wrap_59", 32'(count_bcd), 32'h59);
    check("dn_tc_at_59", 32'(tc), 32'h0);
    up = 1'b1; load = 1'b1;
    #1;
    check("tc_masked_by_load", 32'(tc), 32'h0);
    up = 1'b0; load = 1'b0;
    tick();
    check("dn_58", 32'(count_bcd), 32'h58);

    // Loads: valid, out of range, bad digit, boundary
    load = 1'b1; en = 1'b1; load_val = 8'h45;
    tick();
    check("ld45_count", 32'(count_bcd), 32'h45);
    check("ld45_err", 32'(load_err), 32'h0);
    load_val = 8'h67;
    tick();
    check("ld67_count", 32'(count_bcd), 32'h45);
    check("ld67_err", 32'(load_err), 32'h1);
    load = 1'b0; en = 1'b0;
    tick();
    check("err_one_cycle", 32'(load_err), 32'h0);
    load = 1'b1; load_val = 8'h3A;
    tick();
    check("ld3A_count", 32'(count_bcd), 32'h45);
    check("ld3A_err", 32'(load_err), 32'h1);
    load_val = 8'h60;
    tick();
    check("ld60_count", 32'(count_bcd), 32'h45);
    check("ld60_err", 32'(load_err), 32'h1);
    load_val = 8'h59;
    tick();
    check("ld59_count", 32'(count_bcd), 32'h59);
    check("ld59_err", 32'(load_err), 32'h0);

    // Asynchronous reset mid-cycle at 37 with a pending error pulse
    load_val = 8'h37;
    tick();
    load_val = 8'h67;
    tick();
    check("pre_rst_count", 32'(count_bcd), 32'h37);
    check("pre_rst_err", 32'(load_err), 32'h1);
    load = 1'b0;
    #2 SW = 1'b1;
    #1;
    check("async_rst_count", 32'(count_bcd), 32'h00);
    check("async_rst_err", 32'(load_err), 32'h0);
    check("async_rst_hex", 32'(hex), 32'(14'b1000000_1000000));
    en = 1'b1;
    tick();
    check("rst_dominates_en", 32'(count_bcd), 32'h00);
    #2 SW = 1'b0;
    en = 1'b0;

    // Hold at 09 then carry into tens
    load = 1'b1; load_val = 8'h09;
    tick();
    load = 1'b0;
    repeat (5) tick();
    check("hold_09", 32'(count_bcd), 32'h09);
    check("hold_09_hex", 32'(hex), 32'(14'b1000000_0010000));
    en = 1'b1; up = 1'b1;
    tick();
    check("carry_10", 32'(count_bcd), 32'h10);
    check("carry_10_hex", 32'(hex), 32'(14'b1111001_1000000));
    en = 1'b0;

    // Three-digit counter with leading-zero blanking
    load3 = 1'b1; load_val3 = 12'h007;
    tick();
    check("d3_count_007", 32'(count3), 32'h007);
    check("d3_hex_007", 32'(hex3), 32'(21'b1111111_1111111_1111000));
    load_val3 = 12'h205;
    tick();
    check("d3_hex_205", 32'(hex3), 32'(21'b0100100_1000000_0010010));
    load_val3 = 12'h999;
    tick();
    load3 = 1'b0; en3 = 1'b1; up3 = 1'b1;
    #1;
    check("d3_count_999", 32'(count3), 32'h999);
    check("d3_tc_999", 32'(tc3), 32'h1);
    tick();
    check("d3_wrap_000", 32'(count3), 32'h000);
    check("d3_tc_000", 32'(tc3), 32'h0);
    check("d3_hex_000", 32'(hex3), 32'(21'b1111111_1111111_1000000));
    en3 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_mod_counter.md
BCD_MOD_COUNTER -- requirements
Module: bcd_mod_counter

Interface
REQ-001 Parameter NDIGITS, default 2: number of BCD digits, legal range 1..4.
REQ-002 Parameter MODULUS, default 60: count range is 0..MODULUS-1; legal range 2..10^NDIGITS.
REQ-003 Parameter BLANK_LZ, default 0: 1 blanks leading-zero digits on the display outputs.
REQ-004 Port KEY, input, 1 bit: the clock; all state updates occur on its rising edge.
REQ-005 Port SW, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port en, input, 1 bit: count enable.
REQ-007 Port up, input, 1 bit: count direction, 1 = up and 0 = down.
REQ-008 Port load, input, 1 bit: synchronous load strobe.
REQ-009 Port load_val, input, 4*NDIGITS bits: BCD value to load; digit 0 is in bits [3:0].
REQ-010 Port count_bcd, output, 4*NDIGITS bits: current count in BCD, driven directly from registers.
REQ-011 Port tc, output, 1 bit: terminal-count indication.
REQ-012 Port load_err, output, 1 bit: registered one-cycle pulse flagging a rejected load.
REQ-013 Port hex, output, 7*NDIGITS bits: active-low 7-segment patterns; digit i is in [7i+6:7i] with segment order g..a.

Function
REQ-014 Priority each edge: load > en > hold.
REQ-015 Valid load (every digit <=9 and value < MODULUS): count_bcd <= load_val next edge; load_err <= 0.
REQ-016 Invalid load: count held; load_err <= 1 for exactly one cycle.
REQ-017 en=1, up=1, load=0: count increments by 1 in decimal, with per-digit carry from 9 to 0.
REQ-018 Up at MODULUS-1: next count is 0 (wrap); the value MODULUS never appears on count_bcd.
REQ-019 en=1, up=0, load=0: count decrements by 1 in decimal, with per-digit borrow from 0 to 9.
REQ-020 Down at 0: next count is MODULUS-1.
REQ-021 en=0 and load=0: count held; load_err <= 0.
REQ-022 tc is combinational: tc = en & ~load & (count == (up ? MODULUS-1 : 0)).
REQ-023 tc is high exactly in the cycle that precedes a wrap, for cascading.
REQ-024 Digit decoding, active-low, order g..a:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- any other value = 1111111
REQ-025 BLANK_LZ=1: any digit i>0 that is 0 and has all higher digits 0 outputs 1111111; digit 0 is never blanked.
REQ-026 Changes to up take effect on the next enabled edge; no extra latency.
REQ-027 Count latency: a registered update is visible on count_bcd and hex in the same cycle after the edge.

Reset
REQ-028 While SW=1, count_bcd is 0 and load_err is 0, regardless of KEY, en and load.
REQ-029 While SW=1, hex shows "0" on digit 0; higher digits show "0" if BLANK_LZ=0 and are blank if BLANK_LZ=1.
REQ-030 Reset asserted mid-count clears state immediately, without waiting for a KEY edge.
REQ-031 The first enabled edge after SW deasserts counts from 0.

Structure
REQ-032 A shared package bcd_counter_pkg holds:
- the seven-segment pattern constants for 0..9 and blank
- the BCD digit width constant (4)
- a function that checks whether a BCD digit is valid
REQ-033 Decoding is one sub-module, bcd_seg_decoder (4-bit in, 7-bit out, combinational), instantiated NDIGITS times in a generate loop.
REQ-034 Per-digit increment/decrement, with carry/borrow chaining, is built in a generate loop.
REQ-035 The modulus compare is done on the BCD value; no binary-to-BCD conversion is used.

Verification
REQ-036 Defaults, SW pulse, then en=1 up=1 for 61 edges: count runs 00..59 then returns to 00; tc is high only at 59.
REQ-037 Defaults, up=0 from 00: next value is 59, then 58; tc is high at 00.
REQ-038 Defaults, load with load_val=0x45 and en=1: count becomes 45; load_val=0x67 (>=60) or 0x3A (bad digit): count held and load_err pulses 1 cycle.
REQ-039 Defaults, count at 37, SW asserted between KEY edges: count_bcd is 00 immediately; hex is {1000000,1000000}.
REQ-040 NDIGITS=3, MODULUS=1000, BLANK_LZ=1, count 7: hex = {1111111,1111111,1111000}; count 999 up wraps to 000 with tc=1.
REQ-041 Defaults, count at 9 with en=0 for 5 edges: count stays 09; then en=1 for 1 edge: count becomes 10, with correct digit carry.
